// File: rtl/fma_align_pipe_pkg.sv
// Shared widths, format biases and format encoding for the FMA addend alignment pipe.
package fma_align_pipe_pkg;
    localparam int FMA_NE     = 11;
    localparam int FMA_NF     = 52;
    localparam int FMA_ACNTW  = FMA_NE + 2;
    localparam int FMA_BIAS0  = 1023;
    localparam int FMA_BIAS1  = 127;
    localparam int FMA_STAGES = 2;

    typedef enum logic {
        FMT_WIDE   = 1'b0,
        FMT_NARROW = 1'b1
    } fmt_e;
endpackage

// File: rtl/fma_align_shift.sv
// Combinational addend shifter: places Zm against the product and derives the sticky bit.
module fma_align_shift #(
    parameter int NF    = 52,
    parameter int ACNTW = 13
) (
    input  logic [NF:0]       zm_i,
    input  logic [ACNTW-1:0]  acnt_i,
    input  logic              kill_prod_i,
    input  logic              kill_z_i,
    input  logic              nfp3_sub_i,
    input  logic              z_zero_i,
    input  logic              kill_xy_i,
    output logic [3*NF+3:0]   am_o,
    output logic              sticky_o
);
    logic [4*NF+3:0] sh;

    always_comb begin
        sh       = '0;
        sticky_o = 1'b0;
        // Product dropped (or cancels to NF+3 under subtraction): park Zm just above the product.
        if (kill_prod_i | nfp3_sub_i) begin
            sh       = {{(NF+2){1'b0}}, zm_i, {(2*NF+1){1'b0}}};
            sticky_o = ~kill_xy_i;
        end else if (kill_z_i) begin
            sh       = '0;
            sticky_o = ~z_zero_i;
        end else begin
            sh       = {zm_i, {(3*NF+3){1'b0}}} >> acnt_i;
            sticky_o = |sh[NF-1:0];
        end
    end

    assign am_o = sh[4*NF+3:NF];
endmodule

// File: rtl/fma_align_pipe.sv
// Two-stage FMA addend alignment: stage 1 computes the shift count and kill flags,
// stage 2 shifts Zm. Both stages hold on Stall; Flush drops in-flight valids.
module fma_align_pipe
    import fma_align_pipe_pkg::*;
#(
    parameter int NE    = FMA_NE,
    parameter int NF    = FMA_NF,
    parameter int BIAS0 = FMA_BIAS0,
    parameter int BIAS1 = FMA_BIAS1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InValid,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Fmt,
    input  logic [NE-1:0]     Xe,
    input  logic [NE-1:0]     Ye,
    input  logic [NE-1:0]     Ze,
    input  logic [NF:0]       Zm,
    input  logic              XZero,
    input  logic              YZero,
    input  logic              ZZero,
    input  logic              InvA,
    output logic              OutValid,
    output logic [3*NF+3:0]   Am,
    output logic              ASticky,
    output logic              KillProd,
    output logic              NFPlusThree
);
    localparam int ACNTW  = NE + 2;
    localparam int STAGES = FMA_STAGES;

    fmt_e             fmt;
    logic [ACNTW-1:0] bias;
    logic [ACNTW-1:0] acnt_d, acnt_q;
    logic             kill_xy_d, kill_xy_q;
    logic             kill_prod_d, kill_prod_q;
    logic             kill_z_d, kill_z_q;
    logic             nfp3_d, nfp3_q;
    logic [NF:0]      zm_q;
    logic             z_zero_q, inv_a_q;
    logic [STAGES:1]  vld_pipe_q;

    logic [3*NF+3:0]  am_d, am_q;
    logic             sticky_d, sticky_q;
    logic             kill_prod2_q, nfp3_2_q;

    // Stage 1: alignment count, modulo 2^(NE+2) so negative counts show up in the MSB.
    assign fmt         = fmt_e'(Fmt);
    assign bias        = (fmt == FMT_NARROW) ? ACNTW'(BIAS1) : ACNTW'(BIAS0);
    assign acnt_d      = ACNTW'(Xe) + ACNTW'(Ye) - bias + ACNTW'(NF + 2) - ACNTW'(Ze);
    assign kill_xy_d   = XZero | YZero;
    assign kill_prod_d = (acnt_d[ACNTW-1] & ~ZZero) | kill_xy_d;
    assign kill_z_d    = $signed(acnt_d) > $signed(ACNTW'(3*NF + 3));
    assign nfp3_d      = (&acnt_d) & ~kill_xy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
        end else if (Flush) begin
            vld_pipe_q <= '0;
        end else if (!Stall) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], InValid};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acnt_q      <= '0;
            kill_xy_q   <= 1'b0;
            kill_prod_q <= 1'b0;
            kill_z_q    <= 1'b0;
            nfp3_q      <= 1'b0;
            zm_q        <= '0;
            z_zero_q    <= 1'b0;
            inv_a_q     <= 1'b0;
        end else if (!Stall) begin
            acnt_q      <= acnt_d;
            kill_xy_q   <= kill_xy_d;
            kill_prod_q <= kill_prod_d;
            kill_z_q    <= kill_z_d;
            nfp3_q      <= nfp3_d;
            zm_q        <= Zm;
            z_zero_q    <= ZZero;
            inv_a_q     <= InvA;
        end
    end

    fma_align_shift #(
        .NF    (NF),
        .ACNTW (ACNTW)
    ) u_shift (
        .zm_i        (zm_q),
        .acnt_i      (acnt_q),
        .kill_prod_i (kill_prod_q),
        .kill_z_i    (kill_z_q),
        .nfp3_sub_i  (nfp3_q & inv_a_q),
        .z_zero_i    (z_zero_q),
        .kill_xy_i   (kill_xy_q),
        .am_o        (am_d),
        .sticky_o    (sticky_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            am_q         <= '0;
            sticky_q     <= 1'b0;
            kill_prod2_q <= 1'b0;
            nfp3_2_q     <= 1'b0;
        end else if (!Stall) begin
            am_q         <= am_d;
            sticky_q     <= sticky_d;
            kill_prod2_q <= kill_prod_q;
            nfp3_2_q     <= nfp3_q;
        end
    end

    assign OutValid    = vld_pipe_q[STAGES];
    assign Am          = am_q;
    assign ASticky     = sticky_q;
    assign KillProd    = kill_prod2_q;
    assign NFPlusThree = nfp3_2_q;
endmodule

// File: tb/tb_fma_align_pipe.sv
// Directed-vector bench for fma_align_pipe (NE=11, NF=52).
module tb_fma_align_pipe;
    logic          clk = 1'b0;
    logic          reset;
    logic          InValid, Stall, Flush, Fmt;
    logic [10:0]   Xe, Ye, Ze;
    logic [52:0]   Zm;
    logic          XZero, YZero, ZZero, InvA;
    logic          OutValid, ASticky, KillProd, NFPlusThree;
    logic [159:0]  Am;

    int total = 0;
    int bad   = 0;

    localparam logic [52:0]  ZH  = 53'h10_0000_0000_0000;
    localparam logic [52:0]  ZM  = 53'h1F_0123_4567_89AB;
    localparam logic [159:0] ONE = 160'd1;

    typedef struct {
        string        name;
        logic         fmt;
        logic [10:0]  xe, ye, ze;
        logic [52:0]  zm;
        logic         xz, yz, zz, ia;
        logic [159:0] am;
        logic         st, kp, n3;
    } vec_t;

    fma_align_pipe dut (
        .clk(clk), .reset(reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
        .Fmt(Fmt), .Xe(Xe), .Ye(Ye), .Ze(Ze), .Zm(Zm),
        .XZero(XZero), .YZero(YZero), .ZZero(ZZero), .InvA(InvA),
        .OutValid(OutValid), .Am(Am), .ASticky(ASticky), .KillProd(KillProd),
        .NFPlusThree(NFPlusThree)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic f, int xe, int ye, int ze, logic [52:0] zm,
                                logic [3:0] flags, logic [159:0] am, logic st, logic kp, logic n3);
        vec_t v;
        v.name = n; v.fmt = f;
        v.xe = 11'(xe); v.ye = 11'(ye); v.ze = 11'(ze); v.zm = zm;
        {v.xz, v.yz, v.zz, v.ia} = flags;
        v.am = am; v.st = st; v.kp = kp; v.n3 = n3;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Fmt = v.fmt; Xe = v.xe; Ye = v.ye; Ze = v.ze; Zm = v.zm;
        XZero = v.xz; YZero = v.yz; ZZero = v.zz; InvA = v.ia;
    endtask

    task automatic test_reset();
        reset = 1'b1; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
        Fmt = 1'b0; Xe = '0; Ye = '0; Ze = '0; Zm = '0;
        XZero = 1'b0; YZero = 1'b0; ZZero = 1'b0; InvA = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({OutValid, KillProd, NFPlusThree, ASticky, Am} !== 164'd0) begin
            bad++;
            $display("FAIL reset_state: got ov=%0b kp=%0b n3=%0b st=%0b am=%h, want all zero",
                     OutValid, KillProd, NFPlusThree, ASticky, Am);
        end
        reset = 1'b0;
    endtask

    task automatic test_align();
        vec_t vq[$];
        vq.push_back(mk("aligned54",   0, 1023, 1023, 1023, ZH,          4'b0000, ONE << 105, 0, 0, 0));
        vq.push_back(mk("shift44",     0, 1023, 1023, 1033, ZH,          4'b0000, ONE << 115, 0, 0, 0));
        vq.push_back(mk("shift150_st", 0, 1023, 1023, 927,  ZH | 53'd1,  4'b0000, ONE << 9,   1, 0, 0));
        vq.push_back(mk("shift150",    0, 1023, 1023, 927,  ZH,          4'b0000, ONE << 9,   0, 0, 0));
        vq.push_back(mk("shift159",    0, 1023, 1023, 918,  ZH | (ZH >> 1), 4'b0000, ONE,     1, 0, 0));
        vq.push_back(mk("killz160",    0, 1023, 1023, 917,  ZH,          4'b0000, '0,         1, 0, 0));
        vq.push_back(mk("killz_big",   0, 1023, 1023, 1,    ZH,          4'b0000, '0,         1, 0, 0));
        vq.push_back(mk("killz_zzero", 0, 1023, 1023, 1,    ZH,          4'b0010, '0,         0, 0, 0));
        vq.push_back(mk("neg_killp",   0, 1,    1,    1023, ZM,          4'b0000, 160'(ZM) << 53, 1, 1, 0));
        vq.push_back(mk("xzero_killp", 0, 1023, 1023, 1023, ZH,          4'b1000, ONE << 105, 0, 1, 0));
        vq.push_back(mk("yzero_killp", 0, 1023, 1023, 1023, ZH,          4'b0110, ONE << 105, 0, 1, 0));
        vq.push_back(mk("nfp3_sub",    0, 1023, 1023, 1078, ZM,          4'b0001, 160'(ZM) << 53, 1, 1, 1));
        vq.push_back(mk("nfp3_add",    0, 1023, 1023, 1078, 53'd0,       4'b0010, '0,         0, 0, 1));
        vq.push_back(mk("narrow54",    1, 127,  127,  127,  ZH,          4'b0000, ONE << 105, 0, 0, 0));
        vq.push_back(mk("narrow950",   1, 1023, 1023, 1023, ZH,          4'b0000, '0,         1, 0, 0));
        foreach (vq[i]) begin
            drive(vq[i]);
            InValid = 1'b1;
            @(posedge clk); #1 InValid = 1'b0;
            @(posedge clk); #1;
            total++;
            if ({OutValid, KillProd, NFPlusThree, ASticky, Am} !==
                {1'b1, vq[i].kp, vq[i].n3, vq[i].st, vq[i].am}) begin
                bad++;
                $display("FAIL %s: got ov=%0b kp=%0b n3=%0b st=%0b am=%h, want ov=1 kp=%0b n3=%0b st=%0b am=%h",
                         vq[i].name, OutValid, KillProd, NFPlusThree, ASticky, Am,
                         vq[i].kp, vq[i].n3, vq[i].st, vq[i].am);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t a, b, c;
        a = mk("A", 0, 1023, 1023, 1023, ZH, 4'b0000, ONE << 105, 0, 0, 0);
        b = mk("B", 0, 1023, 1023, 1033, ZH, 4'b0000, ONE << 115, 0, 0, 0);
        c = mk("C", 0, 1, 1, 1023, ZM, 4'b0000, 160'(ZM) << 53, 1, 1, 0);
        drive(a); InValid = 1'b1;
        @(posedge clk); #1 drive(b);
        @(posedge clk); #1;
        total++;
        if ({OutValid, Am} !== {1'b1, a.am}) begin
            bad++;
            $display("FAIL b2b_A: got ov=%0b am=%h, want ov=1 am=%h", OutValid, Am, a.am);
        end
        drive(c);
        @(posedge clk); #1;
        total++;
        if ({OutValid, Am} !== {1'b1, b.am}) begin
            bad++;
            $display("FAIL b2b_B: got ov=%0b am=%h, want ov=1 am=%h", OutValid, Am, b.am);
        end
        InValid = 1'b0; Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({OutValid, KillProd, Am} !== {1'b1, 1'b0, b.am}) begin
                bad++;
                $display("FAIL stall_hold%0d: got ov=%0b kp=%0b am=%h, want ov=1 kp=0 am=%h",
                         k, OutValid, KillProd, Am, b.am);
            end
        end
        Flush = 1'b1;
        @(posedge clk); #1;
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got ov=%0b, want ov=0", OutValid);
        end
        Flush = 1'b0; Stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if (OutValid !== 1'b0) begin
                bad++;
                $display("FAIL flushed_C%0d: got ov=%0b, want ov=0", k, OutValid);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t c, a;
        c = mk("C", 0, 1, 1, 1023, ZM, 4'b0000, 160'(ZM) << 53, 1, 1, 0);
        a = mk("A", 0, 1023, 1023, 1023, ZH, 4'b0000, ONE << 105, 0, 0, 0);
        drive(c); InValid = 1'b1;
        @(posedge clk); #1 InValid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({OutValid, KillProd} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset: got ov=%0b kp=%0b, want ov=1 kp=1", OutValid, KillProd);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({OutValid, KillProd, NFPlusThree, ASticky, Am} !== 164'd0) begin
            bad++;
            $display("FAIL async_reset: got ov=%0b kp=%0b st=%0b am=%h, want all zero",
                     OutValid, KillProd, ASticky, Am);
        end
        @(posedge clk); #1 reset = 1'b0;
        drive(a); InValid = 1'b1;
        @(posedge clk); #1 InValid = 1'b0;
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_lat1: got ov=%0b, want ov=0", OutValid);
        end
        @(posedge clk); #1;
        total++;
        if ({OutValid, Am} !== {1'b1, a.am}) begin
            bad++;
            $display("FAIL post_reset_op: got ov=%0b am=%h, want ov=1 am=%h", OutValid, Am, a.am);
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
